// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one dot product through an external MAC unit.
// It reads N_TAPS sample/coefficient pairs from synchronous memories, feeds
// them to the MAC, waits out the MAC pipeline, and then presents the
// accumulated result (raw and shifted/saturated) on a valid/ready stream.
module mac_seq_ctrl #(
  parameter int N_TAPS    = 8,
  parameter int ADDR_W    = 4,
  parameter int OUT_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic        [ADDR_W-1:0] smp_base,
  output logic                     busy,
  output logic                     smp_rd_en,
  output logic        [ADDR_W-1:0] smp_rd_addr,
  output logic                     coef_rd_en,
  output logic        [ADDR_W-1:0] coef_rd_addr,
  input  logic signed [15:0]       smp_rd_data,
  input  logic signed [15:0]       coef_rd_data,
  output logic                     mac_rst_n,
  output logic                     mac_ce,
  output logic signed [15:0]       mac_a,
  output logic signed [15:0]       mac_b,
  input  logic signed [31:0]       mac_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [15:0]       out_data,
  output logic signed [31:0]       out_raw
);

  // One extra bit so the tap counter can be compared against N_TAPS = 2^ADDR_W.
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, OUT} state_t;

  state_t                    state_q, state_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic        [ADDR_W-1:0]  base_q, base_d;
  logic                      rd_en_q, rd_en_d;
  logic        [ADDR_W-1:0]  smp_addr_q, smp_addr_d;
  logic        [ADDR_W-1:0]  coef_addr_q, coef_addr_d;
  logic                      busy_q, busy_d;
  logic                      valid_q, valid_d;
  logic signed [31:0]        raw_q, raw_d;
  logic signed [15:0]        data_q, data_d;
  logic signed [31:0]        shifted;
  logic signed [15:0]        sat_val;
  logic        [CNT_W-1:0]   cnt_p2;
  logic        [ADDR_W-1:0]  base_p1;
  logic                      in_run;

  // Floor shift of the MAC result, then clamp into the 16-bit signed range.
  always_comb begin
    shifted = mac_result >>> OUT_SHIFT;
    if (shifted > 32'sd32767) begin
      sat_val = 16'sh7FFF;
    end else if (shifted < -32'sd32768) begin
      sat_val = 16'sh8000;
    end else begin
      sat_val = shifted[15:0];
    end
  end

  // Next-state and next-output decode; read requests run one cycle ahead of
  // the data the MAC consumes, so each state requests the following tap.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    rd_en_d     = 1'b0;
    smp_addr_d  = '0;
    coef_addr_d = '0;
    valid_d     = valid_q;
    raw_d       = raw_q;
    data_d      = data_q;
    cnt_p2      = cnt_q + CNT_W'(2);
    base_p1     = base_q + ADDR_W'(1);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = CLEAR;
          base_d      = smp_base;
          rd_en_d     = 1'b1;
          smp_addr_d  = smp_base;
          coef_addr_d = '0;
        end
      end
      CLEAR: begin
        state_d = RUN;
        cnt_d   = '0;
        if (N_TAPS > 1) begin
          rd_en_d     = 1'b1;
          smp_addr_d  = base_p1;
          coef_addr_d = ADDR_W'(1);
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(N_TAPS - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_p2 < CNT_W'(N_TAPS)) begin
            rd_en_d     = 1'b1;
            smp_addr_d  = base_q + cnt_p2[ADDR_W-1:0];
            coef_addr_d = cnt_p2[ADDR_W-1:0];
          end
        end
      end
      DRAIN: begin
        // Two cycles: MAC input register, then its accumulate stage.
        if (cnt_q[0]) begin
          state_d = OUT;
          cnt_d   = '0;
          valid_d = 1'b1;
          raw_d   = mac_result;
          data_d  = sat_val;
        end else begin
          cnt_d = CNT_W'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      rd_en_q     <= 1'b0;
      smp_addr_q  <= '0;
      coef_addr_q <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      raw_q       <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      rd_en_q     <= rd_en_d;
      smp_addr_q  <= smp_addr_d;
      coef_addr_q <= coef_addr_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      raw_q       <= raw_d;
      data_q      <= data_d;
    end
  end

  // Outputs are forced to their idle values for as long as reset is held.
  assign busy         = busy_q & ~reset;
  assign out_valid    = valid_q & ~reset;
  assign out_raw      = reset ? 32'sd0 : raw_q;
  assign out_data     = reset ? 16'sd0 : data_q;
  assign smp_rd_en    = rd_en_q & ~reset;
  assign coef_rd_en   = rd_en_q & ~reset;
  assign smp_rd_addr  = reset ? '0 : smp_addr_q;
  assign coef_rd_addr = reset ? '0 : coef_addr_q;

  // Read data flows straight into the MAC while running; zero otherwise.
  assign in_run    = (state_q == RUN) && !reset;
  assign mac_ce    = in_run;
  assign mac_a     = in_run ? smp_rd_data : 16'sd0;
  assign mac_b     = in_run ? coef_rd_data : 16'sd0;
  assign mac_rst_n = !reset && (state_q != CLEAR);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Testbench for mac_seq_ctrl: synchronous sample/coefficient memories and a
// two-stage MAC model around the controller, with a dot-product reference.
module tb_mac_seq_ctrl;
  localparam int NT = 4;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset, start, out_ready;
  logic [AW-1:0] smp_base;
  logic busy, smp_rd_en, coef_rd_en;
  logic [AW-1:0] smp_rd_addr, coef_rd_addr;
  logic signed [15:0] smp_rd_data = '0;
  logic signed [15:0] coef_rd_data = '0;
  logic mac_rst_n, mac_ce;
  logic signed [15:0] mac_a, mac_b;
  logic signed [31:0] mac_result;
  logic out_valid;
  logic signed [15:0] out_data;
  logic signed [31:0] out_raw;

  logic sh_busy, sh_smp_rd_en, sh_coef_rd_en, sh_mac_rst_n, sh_mac_ce, sh_out_valid;
  logic [AW-1:0] sh_smp_rd_addr, sh_coef_rd_addr;
  logic signed [15:0] sh_mac_a, sh_mac_b, sh_out_data;
  logic signed [31:0] sh_out_raw;

  int n_checks = 0;
  int n_fail = 0;

  logic signed [15:0] smp_mem [DEPTH];
  logic signed [15:0] coef_mem [DEPTH];
  int smp_log[$];
  int coef_log[$];

  always #5 clk = ~clk;

  mac_seq_ctrl #(.N_TAPS(NT), .ADDR_W(AW), .OUT_SHIFT(0)) dut (
    .clk(clk), .reset(reset), .start(start), .smp_base(smp_base), .busy(busy),
    .smp_rd_en(smp_rd_en), .smp_rd_addr(smp_rd_addr),
    .coef_rd_en(coef_rd_en), .coef_rd_addr(coef_rd_addr),
    .smp_rd_data(smp_rd_data), .coef_rd_data(coef_rd_data),
    .mac_rst_n(mac_rst_n), .mac_ce(mac_ce), .mac_a(mac_a), .mac_b(mac_b),
    .mac_result(mac_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_raw(out_raw)
  );

  // Same sequence, shifted output: shares memories and MAC with the main DUT.
  mac_seq_ctrl #(.N_TAPS(NT), .ADDR_W(AW), .OUT_SHIFT(4)) dut_sh (
    .clk(clk), .reset(reset), .start(start), .smp_base(smp_base), .busy(sh_busy),
    .smp_rd_en(sh_smp_rd_en), .smp_rd_addr(sh_smp_rd_addr),
    .coef_rd_en(sh_coef_rd_en), .coef_rd_addr(sh_coef_rd_addr),
    .smp_rd_data(smp_rd_data), .coef_rd_data(coef_rd_data),
    .mac_rst_n(sh_mac_rst_n), .mac_ce(sh_mac_ce), .mac_a(sh_mac_a), .mac_b(sh_mac_b),
    .mac_result(mac_result), .out_valid(sh_out_valid), .out_ready(out_ready),
    .out_data(sh_out_data), .out_raw(sh_out_raw)
  );

  // Synchronous-read memories.
  always @(posedge clk) begin
    if (smp_rd_en) smp_rd_data <= smp_mem[smp_rd_addr];
    if (coef_rd_en) coef_rd_data <= coef_mem[coef_rd_addr];
  end

  // MAC unit: input register stage, then accumulate stage.
  logic signed [15:0] a_r, b_r;
  logic signed [31:0] a_x, b_x, acc;
  logic v_r;
  assign a_x = a_r;
  assign b_x = b_r;
  assign mac_result = acc;
  always @(posedge clk) begin
    if (!mac_rst_n) begin
      a_r <= '0; b_r <= '0; v_r <= 1'b0; acc <= '0;
    end else begin
      v_r <= mac_ce;
      if (mac_ce) begin a_r <= mac_a; b_r <= mac_b; end
      if (v_r) acc <= acc + a_x * b_x;
    end
  end

  // Record every read request address.
  always @(negedge clk) begin
    if (smp_rd_en) smp_log.push_back(int'(smp_rd_addr));
    if (coef_rd_en) coef_log.push_back(int'(coef_rd_addr));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain dot product with 32-bit wrap, sample index modulo depth.
  function automatic int model_raw(input int base);
    int s, a, c;
    s = 0;
    for (int k = 0; k < NT; k++) begin
      a = smp_mem[(base + k) % DEPTH];
      c = coef_mem[k];
      s = s + a * c;
    end
    return s;
  endfunction

  function automatic int sat16(input int raw, input int sh);
    int v;
    v = raw >>> sh;
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic bit addr_seq_ok(input int base);
    if (smp_log.size() != NT || coef_log.size() != NT) return 1'b0;
    for (int k = 0; k < NT; k++)
      if (smp_log[k] != (base + k) % DEPTH || coef_log[k] != k) return 1'b0;
    return 1'b1;
  endfunction

  task automatic rand_mem();
    for (int i = 0; i < DEPTH; i++) begin
      smp_mem[i] = 16'($urandom);
      coef_mem[i] = 16'($urandom);
    end
  endtask

  // Drives one transaction from a negedge; returns at the negedge after the handshake.
  task automatic run_op(input int base, input int rdelay, output int lat, output int vcnt,
                        output int raw, output int d0, output int d1, output bit stable);
    smp_log.delete();
    coef_log.delete();
    start = 1'b1;
    smp_base = AW'(base);
    out_ready = (rdelay == 0);
    @(negedge clk);
    start = 1'b0;
    smp_base = AW'($urandom_range(DEPTH - 1, 0));
    lat = 0;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    raw = out_raw;
    d0 = out_data;
    d1 = sh_out_data;
    stable = 1'b1;
    vcnt = 0;
    for (int i = 0; i < rdelay; i++) begin
      if (!out_valid || !busy || out_raw !== raw || out_data !== d0) stable = 1'b0;
      vcnt++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    while (out_valid && vcnt < 300) begin vcnt++; @(negedge clk); end
    out_ready = 1'b0;
    $display("op base=%0d rdelay=%0d lat=%0d valid_cycles=%0d raw=%0d data=%0d data_sh=%0d",
             base, rdelay, lat, vcnt, raw, d0, d1);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; out_ready = 1'b1; smp_base = 4'd7;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, out_valid, smp_rd_en, coef_rd_en, mac_ce} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 00000", {busy, out_valid, smp_rd_en, coef_rd_en, mac_ce});
    end
    n_checks++;
    if ({smp_rd_addr, coef_rd_addr} !== '0) begin
      n_fail++; $display("FAIL reset_addr: got %0d/%0d required 0/0", smp_rd_addr, coef_rd_addr);
    end
    n_checks++;
    if ({mac_a, mac_b} !== '0) begin
      n_fail++; $display("FAIL reset_mac_ab: got %0d/%0d required 0/0", mac_a, mac_b);
    end
    n_checks++;
    if ({out_data, out_raw} !== '0) begin
      n_fail++; $display("FAIL reset_out: got %0d/%0d required 0/0", out_data, out_raw);
    end
    n_checks++;
    if (mac_rst_n !== 1'b0) begin
      n_fail++; $display("FAIL reset_mac_rst_n: got %b required 0", mac_rst_n);
    end
    start = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || mac_rst_n !== 1'b1) begin
      n_fail++; $display("FAIL idle_after_reset: busy=%b mac_rst_n=%b required 0/1", busy, mac_rst_n);
    end
  endtask

  task automatic test_basic();
    int lat, vcnt, raw, d0, d1; bit st;
    for (int i = 0; i < DEPTH; i++) begin smp_mem[i] = '0; coef_mem[i] = '0; end
    for (int k = 0; k < NT; k++) begin
      smp_mem[k] = 16'(10 * (k + 1));
      coef_mem[k] = 16'(k + 1);
    end
    @(negedge clk);
    run_op(0, 0, lat, vcnt, raw, d0, d1, st);
    n_checks++;
    if (raw !== 300) begin n_fail++; $display("FAIL basic_raw: got %0d required 300", raw); end
    n_checks++;
    if (d0 !== 300) begin n_fail++; $display("FAIL basic_data: got %0d required 300", d0); end
    n_checks++;
    if (d1 !== 18) begin n_fail++; $display("FAIL basic_data_shift: got %0d required 18", d1); end
    n_checks++;
    if (lat !== 7) begin n_fail++; $display("FAIL basic_latency: got %0d required 7", lat); end
    n_checks++;
    if (vcnt !== 1) begin n_fail++; $display("FAIL basic_valid_len: got %0d required 1", vcnt); end
    n_checks++;
    if (!addr_seq_ok(0)) begin
      n_fail++; $display("FAIL basic_addr_seq: got %0d entries required %0d in order", smp_log.size(), NT);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_saturation();
    int lat, vcnt, raw, d0, d1; bit st;
    for (int i = 0; i < DEPTH; i++) begin smp_mem[i] = 16'sd1000; coef_mem[i] = 16'sd1000; end
    run_op(0, 0, lat, vcnt, raw, d0, d1, st);
    n_checks++;
    if (raw !== 4000000) begin n_fail++; $display("FAIL sat_pos_raw: got %0d required 4000000", raw); end
    n_checks++;
    if (d0 !== 32767 || d1 !== 32767) begin
      n_fail++; $display("FAIL sat_pos_data: got %0d/%0d required 32767/32767", d0, d1);
    end
    for (int i = 0; i < DEPTH; i++) coef_mem[i] = -16'sd1000;
    run_op(3, 0, lat, vcnt, raw, d0, d1, st);
    n_checks++;
    if (raw !== -4000000) begin n_fail++; $display("FAIL sat_neg_raw: got %0d required -4000000", raw); end
    n_checks++;
    if (d0 !== -32768 || d1 !== -32768) begin
      n_fail++; $display("FAIL sat_neg_data: got %0d/%0d required -32768/-32768", d0, d1);
    end
  endtask

  task automatic test_shift();
    int lat, vcnt, raw, d0, d1; bit st;
    for (int k = 0; k < NT; k++) begin
      smp_mem[k] = 16'(10 * (k + 1));
      coef_mem[k] = 16'(-(k + 1));
    end
    run_op(0, 0, lat, vcnt, raw, d0, d1, st);
    n_checks++;
    if (raw !== -300) begin n_fail++; $display("FAIL shift_raw: got %0d required -300", raw); end
    n_checks++;
    if (d1 !== -19) begin n_fail++; $display("FAIL shift_data: got %0d required -19", d1); end
    n_checks++;
    if (d0 !== -300) begin n_fail++; $display("FAIL shift0_data: got %0d required -300", d0); end
  endtask

  task automatic test_wrap();
    int lat, vcnt, raw, d0, d1, exp; bit st;
    rand_mem();
    exp = model_raw(14);
    run_op(14, 0, lat, vcnt, raw, d0, d1, st);
    n_checks++;
    if (!addr_seq_ok(14)) begin
      n_fail++;
      $display("FAIL wrap_addr_seq: got %0d entries (first %0d) required 14,15,0,1",
               smp_log.size(), (smp_log.size() > 0) ? smp_log[0] : -1);
    end
    n_checks++;
    if (raw !== exp || d0 !== sat16(exp, 0)) begin
      n_fail++; $display("FAIL wrap_sum: got %0d/%0d required %0d/%0d", raw, d0, exp, sat16(exp, 0));
    end
  endtask

  task automatic test_backpressure();
    int lat, raw0, d0, b, b2, exp;
    rand_mem();
    b = 5;
    b2 = 9;
    out_ready = 1'b0; start = 1'b1; smp_base = AW'(b);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat !== NT + 3) begin n_fail++; $display("FAIL bp_latency: got %0d required %0d", lat, NT + 3); end
    raw0 = out_raw;
    d0 = out_data;
    exp = model_raw(b);
    n_checks++;
    if (raw0 !== exp) begin n_fail++; $display("FAIL bp_raw: got %0d required %0d", raw0, exp); end
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      smp_base = AW'($urandom_range(DEPTH - 1, 0));
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_raw !== raw0 || out_data !== d0) begin
        n_fail++;
        $display("FAIL bp_hold: cycle %0d valid=%b busy=%b raw=%0d data=%0d required 1/1/%0d/%0d",
                 i, out_valid, busy, out_raw, out_data, raw0, d0);
      end
    end
    // start is high during the handshake cycle and stays high into IDLE.
    start = 1'b1; out_ready = 1'b1; smp_base = AW'(b2);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_handshake_start: valid=%b busy=%b required 0/0", out_valid, busy);
    end
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_b2b_accept: busy=%b required 1", busy); end
    lat = 0;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    exp = model_raw(b2);
    n_checks++;
    if (lat !== NT + 3 || out_raw !== exp) begin
      n_fail++; $display("FAIL bp_b2b_result: lat=%0d raw=%0d required %0d/%0d", lat, out_raw, NT + 3, exp);
    end
    $display("op base=%0d backpressure b2b lat=%0d raw=%0d", b2, lat, out_raw);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done: valid=%b required 0", out_valid); end
  endtask

  task automatic test_reset_mid_run();
    int lat, vcnt, raw, d0, d1, b, exp; bit st;
    rand_mem();
    b = $urandom_range(DEPTH - 1, 0);
    start = 1'b1; smp_base = AW'(b); out_ready = 1'b1;
    @(negedge clk);            // CLEAR
    start = 1'b0;
    repeat (3) @(negedge clk); // RUN k=0,1,2
    n_checks++;
    if (busy !== 1'b1 || mac_ce !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_in_run: busy=%b mac_ce=%b required 1/1", busy, mac_ce);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, out_valid, smp_rd_en, coef_rd_en, mac_ce, mac_rst_n} !== 6'b0 ||
        {smp_rd_addr, coef_rd_addr, mac_a, mac_b, out_data, out_raw} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: busy=%b valid=%b ce=%b rst_n=%b raw=%0d required all 0",
                         busy, out_valid, mac_ce, mac_rst_n, out_raw);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || mac_rst_n !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_idle: busy=%b valid=%b rst_n=%b required 0/0/1", busy, out_valid, mac_rst_n);
    end
    b = $urandom_range(DEPTH - 1, 0);
    exp = model_raw(b);
    run_op(b, 0, lat, vcnt, raw, d0, d1, st);
    n_checks++;
    if (lat !== NT + 3) begin n_fail++; $display("FAIL rst_mid_latency: got %0d required %0d", lat, NT + 3); end
    n_checks++;
    if (raw !== exp || d0 !== sat16(exp, 0)) begin
      n_fail++; $display("FAIL rst_mid_result: got %0d/%0d required %0d/%0d", raw, d0, exp, sat16(exp, 0));
    end
  endtask

  task automatic test_random_back_to_back();
    int lat, vcnt, raw, d0, d1, b, rd, exp; bit st;
    for (int t = 0; t < 16; t++) begin
      rand_mem();
      b = $urandom_range(DEPTH - 1, 0);
      rd = $urandom_range(3, 0);
      exp = model_raw(b);
      run_op(b, rd, lat, vcnt, raw, d0, d1, st);
      n_checks++;
      if (lat !== NT + 3) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d required %0d", t, lat, NT + 3); end
      n_checks++;
      if (vcnt !== rd + 1) begin n_fail++; $display("FAIL rand_valid_len[%0d]: got %0d required %0d", t, vcnt, rd + 1); end
      n_checks++;
      if (raw !== exp) begin n_fail++; $display("FAIL rand_raw[%0d]: got %0d required %0d", t, raw, exp); end
      n_checks++;
      if (d0 !== sat16(exp, 0)) begin n_fail++; $display("FAIL rand_data[%0d]: got %0d required %0d", t, d0, sat16(exp, 0)); end
      n_checks++;
      if (d1 !== sat16(exp, 4)) begin n_fail++; $display("FAIL rand_data_shift[%0d]: got %0d required %0d", t, d1, sat16(exp, 4)); end
      n_checks++;
      if (!st) begin n_fail++; $display("FAIL rand_stable[%0d]: got unstable required stable", t); end
      n_checks++;
      if (!addr_seq_ok(b)) begin
        n_fail++; $display("FAIL rand_addr_seq[%0d]: got %0d entries required %0d from base %0d", t, smp_log.size(), NT, b);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; smp_base = '0;
    for (int i = 0; i < DEPTH; i++) begin smp_mem[i] = '0; coef_mem[i] = '0; end
    test_reset();
    test_basic();
    test_saturation();
    test_shift();
    test_wrap();
    test_backpressure();
    test_reset_mid_run();
    test_random_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
Parameters:
REQ-001 SHALL have parameter N_TAPS, default 8: number of products per dot product, legal range 1..2^ADDR_W.
REQ-002 SHALL have parameter ADDR_W, default 4: sample/coefficient address width.
REQ-003 SHALL have parameter OUT_SHIFT, default 0: arithmetic right shift applied before saturation, legal range 0..16.
Ports:
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request one dot product; accepted only in IDLE.
REQ-007 SHALL have port smp_base, input, ADDR_W bits: sample start address, captured on start acceptance.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have ports smp_rd_en/coef_rd_en (output, 1 bit) and smp_rd_addr/coef_rd_addr (output, ADDR_W): synchronous read requests; data returns the next cycle.
REQ-010 SHALL have ports smp_rd_data and coef_rd_data, input, 16 bits signed: read data.
REQ-011 SHALL have ports mac_rst_n (output, 1), mac_ce (output, 1), mac_a (output, 16 signed), mac_b (output, 16 signed) and mac_result (input, 32 signed): the MAC unit drive and its result.
REQ-012 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 16 signed) and out_raw (output, 32 signed): result stream.

Function
REQ-013 SHALL implement states IDLE, CLEAR, RUN, DRAIN and OUT, with transitions:
- IDLE->CLEAR on start.
- CLEAR->RUN after 1 cycle.
- RUN->DRAIN after N_TAPS cycles.
- DRAIN->OUT after 2 cycles.
- OUT->IDLE on the cycle where out_valid and out_ready are both high.
REQ-014 SHALL, in CLEAR: drive mac_rst_n=0 and mac_ce=0, assert both rd_en, and drive smp_rd_addr=smp_base and coef_rd_addr=0.
REQ-015 SHALL, in RUN cycle k (k=0..N_TAPS-1):
- drive mac_ce=1, mac_a=smp_rd_data, mac_b=coef_rd_data (item k);
- for k<N_TAPS-1, request smp_rd_addr=(smp_base+k+1) mod 2^ADDR_W and coef_rd_addr=k+1;
- for k=N_TAPS-1, drive rd_en=0.
REQ-016 SHALL, outside RUN, drive mac_ce=0 and mac_a=mac_b=0; mac_rst_n=1 except in CLEAR or while reset is high.
REQ-017 SHALL wait 2 DRAIN cycles, to cover the MAC's input register plus accumulate stage, then capture mac_result into out_raw at the end of the second DRAIN cycle.
REQ-018 SHALL compute out_data = saturate16(out_raw >>> OUT_SHIFT):
- arithmetic floor shift;
- clamp to the range [-32768, 32767].
REQ-019 SHALL drive out_valid=1 in OUT, and keep out_data and out_raw stable until the handshake completes.
REQ-020 SHALL give a latency from the start-acceptance edge to out_valid rising of N_TAPS+3 cycles.
REQ-021 SHALL ignore start while busy; start asserted in the handshake cycle is also ignored, and start in the following IDLE cycle is accepted (back-to-back operation).
REQ-022 SHALL, if out_ready is already high on the first OUT cycle, complete the transfer in that cycle, with out_valid high for exactly 1 cycle.
REQ-023 SHALL wrap sample addresses modulo 2^ADDR_W; coefficient addresses never wrap.
REQ-024 SHALL hold the captured smp_base for the whole operation; smp_base changes after acceptance have no effect.
REQ-025 SHALL not itself saturate the accumulator; MAC-side 32-bit wrap is passed through to out_raw unchanged.

Reset
REQ-026 SHALL, while reset is high, force state to IDLE and drive:
- busy=0, out_valid=0, out_data=0, out_raw=0;
- both rd_en=0, rd_addr=0;
- mac_ce=0, mac_a=0, mac_b=0, mac_rst_n=0.
REQ-027 SHALL, on reset asserted mid-operation in any state, abandon the operation with no out_valid pulse, and accept a new start on the first cycle after reset deasserts.

Verification
REQ-028 SHALL be verified by basic: N_TAPS=4, samples [10,20,30,40] at base 0, coefs [1,2,3,4], out_ready=1 -> out_raw=300, out_data=300, out_valid exactly 7 cycles after start.
REQ-029 SHALL be verified by saturation: N_TAPS=4, all samples 1000, coefs 1000 -> out_raw=4000000, out_data=32767; coefs -1000 -> out_data=-32768.
REQ-030 SHALL be verified by shift: OUT_SHIFT=4, raw -300 -> out_data=-19.
REQ-031 SHALL be verified by wrap: ADDR_W=4, N_TAPS=4, smp_base=14 -> smp_rd_addr sequence 14,15,0,1, and the correct sum.
REQ-032 SHALL be verified by backpressure: out_ready low for 5 cycles, with start pulsed during OUT -> out_data stable, start ignored, busy high; out_ready=1 -> IDLE next cycle, and a start then is accepted.
REQ-033 SHALL be verified by reset mid-RUN: reset at RUN k=2 for 1 cycle -> all outputs at reset values next cycle, no out_valid; a fresh start then yields the correct result.
